// File: rtl/adccfg_slave_if.sv
// Serial configuration pins plus the register-file access port of adccfg_slave.
// The slave modport is the block's view; the master modport is the host or
// pad side together with the register file.
interface adccfg_slave_if;
  logic        csb;
  logic        sclk;
  logic        sdi;
  logic        sdo;
  logic        sdo_oe;
  logic [12:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic        reg_re;

  modport slave (
    input  csb, sclk, sdi, reg_rdata,
    output sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport master (
    output csb, sclk, sdi, reg_rdata,
    input  sdo, sdo_oe, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/adccfg_slave.sv
// adccfg_slave: 3-wire serial configuration slave for the ADC register file.
// Each frame is 24 bits, MSB first: R/W, W1:W0 (must be 00), a 13-bit address,
// then 8 data bits. csb, sclk and sdi are oversampled on clk through
// SYNC_STAGES flip-flops. All serial edges are detected on the synchronized copies.
module adccfg_slave #(
  parameter int SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic          clk,
  input  logic          rst,
  adccfg_slave_if.slave bus,
  output logic          frame_err,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, INSTR, DATA, DONE, WAITHI} state_t;

  localparam logic [4:0] CNT_HDR  = 5'd15;  // count value when the 16th bit arrives
  localparam logic [4:0] CNT_LAST = 5'd23;  // count value when the 24th bit arrives
  localparam logic [4:0] CNT_SAT  = 5'd25;  // saturation point: more than 24 rises seen

  logic [SYNC_STAGES-1:0] csb_pipe, sclk_pipe, sdi_pipe;
  logic csb_s, sclk_s, sdi_s;
  logic csb_q, sclk_q;
  logic csb_fall, csb_rise, sclk_rise, sclk_fall;

  state_t      state, state_d;
  logic [4:0]  cnt, cnt_d;
  logic [15:0] sr, sr_d;

  logic rw_q, bad_w_q, read_ok, hdr_ok;
  logic frame_start, hdr_ld, data_ld, re_set, we_set, err_set;
  logic re_q;
  logic [7:0] tx;
  logic sdo_q;

  // Synchronize the serial pins and keep a one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only. csb resets
      // low, so WAITHI has to see the pin actually high before it arms.
      csb_pipe  <= '0;
      sclk_pipe <= '0;
      sdi_pipe  <= '0;
      csb_q     <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      csb_pipe  <= {csb_pipe[SYNC_STAGES-2:0], bus.csb};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], bus.sclk};
      sdi_pipe  <= {sdi_pipe[SYNC_STAGES-2:0], bus.sdi};
      csb_q     <= csb_s;
      sclk_q    <= sclk_s;
    end
  end

  assign csb_s     = csb_pipe[SYNC_STAGES-1];
  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign sdi_s     = sdi_pipe[SYNC_STAGES-1];
  assign csb_fall  = csb_q & ~csb_s;
  assign csb_rise  = ~csb_q & csb_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  // FSM state, bit counter and input shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAITHI;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sr    <= sr_d;
    end
  end

  assign hdr_ok = (sr_d[14:13] == 2'b00);

  // Next-state logic and one-cycle action requests for the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d     = state;
    cnt_d       = cnt;
    sr_d        = sr;
    frame_start = 1'b0;
    hdr_ld      = 1'b0;
    data_ld     = 1'b0;
    re_set      = 1'b0;
    we_set      = 1'b0;
    err_set     = 1'b0;
    unique case (state)
      WAITHI: begin
        if (csb_s) state_d = IDLE;
      end
      IDLE: begin
        if (csb_fall) begin
          state_d     = INSTR;
          cnt_d       = '0;
          sr_d        = '0;
          frame_start = 1'b1;
        end
      end
      INSTR, DATA: begin
        if (csb_rise) begin
          // The frame ended early: abort it and flag it as malformed.
          state_d = IDLE;
          err_set = 1'b1;
        end else if (sclk_rise) begin
          sr_d  = {sr[14:0], sdi_s};
          cnt_d = cnt + 5'd1;
          if (state == INSTR && cnt == CNT_HDR) begin
            state_d = DATA;
            hdr_ld  = 1'b1;
            re_set  = sr_d[15] & hdr_ok;
          end else if (state == DATA && cnt == CNT_LAST) begin
            state_d = DONE;
            data_ld = 1'b1;
            we_set  = ~rw_q & ~bad_w_q;
          end
        end
      end
      DONE: begin
        if (csb_rise) begin
          state_d = IDLE;
          err_set = bad_w_q | (cnt == CNT_SAT);
        end else if (sclk_rise && cnt != CNT_SAT) begin
          cnt_d = cnt + 5'd1;
        end
      end
      default: state_d = WAITHI;
    endcase
  end

  // Header flags, register-port address/data, and the single-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q          <= 1'b0;
      bad_w_q       <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
      frame_err     <= 1'b0;
      re_q          <= 1'b0;
    end else begin
      bus.reg_we <= we_set;
      bus.reg_re <= re_set;
      frame_err  <= err_set;
      re_q       <= bus.reg_re;
      if (frame_start) begin
        rw_q    <= 1'b0;
        bad_w_q <= 1'b0;
      end
      if (hdr_ld) begin
        rw_q    <= sr_d[15];
        bad_w_q <= ~hdr_ok;
        // A malformed header leaves the previously latched address in place.
        if (hdr_ok) bus.reg_addr <= sr_d[12:0];
      end
      if (data_ld && we_set) bus.reg_wdata <= sr_d[7:0];
    end
  end

  assign read_ok = rw_q & ~bad_w_q;

  // Read data path: capture rdata one cycle after the read strobe, then shift
  // it out MSB first, moving to the next bit on each sclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx    <= '0;
      sdo_q <= 1'b0;
    end else begin
      if (frame_start) sdo_q <= 1'b0;
      if (re_q) begin
        tx <= bus.reg_rdata;
      end else if (state == DATA && read_ok && sclk_fall) begin
        sdo_q <= tx[7];
        tx    <= {tx[6:0], 1'b0};
      end
    end
  end

  assign bus.sdo_oe = (state == DATA) & read_ok;
  assign bus.sdo    = bus.sdo_oe & sdo_q;
  assign busy       = (state == INSTR) | (state == DATA) | (state == DONE);

endmodule

// File: tb/tb_adccfg_slave.sv
// Testbench for adccfg_slave. It applies a table of directed frames with
// hand-computed results, followed by a hand-written sequence that pulses
// reset partway through a frame.
module tb_adccfg_slave;

  logic clk = 1'b0;
  logic rst;
  logic frame_err;
  logic busy;

  adccfg_slave_if bus ();

  adccfg_slave #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int err_cnt  = 0;

  // Count strobe pulses, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (bus.reg_we) we_cnt++;
    if (bus.reg_re) re_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [23:0] frame;
    int          rises;
    logic [7:0]  rdata;
    int          exp_we;
    int          exp_re;
    int          exp_err;
    logic [12:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        chk_sdo;
    logic [7:0]  exp_sdo;
    int          exp_oe;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [23:0] frame, input int rises,
                              input logic [7:0] rdata, input int we, input int re, input int err,
                              input logic [12:0] addr, input logic [7:0] wdata,
                              input logic chk_sdo, input logic [7:0] sdo, input int oe);
    vec_t v;
    v.name = name; v.frame = frame; v.rises = rises; v.rdata = rdata;
    v.exp_we = we; v.exp_re = re; v.exp_err = err;
    v.exp_addr = addr; v.exp_wdata = wdata;
    v.chk_sdo = chk_sdo; v.exp_sdo = sdo; v.exp_oe = oe;
    return v;
  endfunction

  // One frame with an sclk period of 8 clk. Rises beyond 24 shift in zeros.
  // sdo/sdo_oe are sampled just before each rise, where the host samples them.
  task automatic run_frame(input logic [23:0] frame, input int rises,
                           output logic [7:0] rd_bits, output int oe_hits,
                           output int oe_stray, output logic busy_mid);
    rd_bits  = '0;
    oe_hits  = 0;
    oe_stray = 0;
    busy_mid = 1'b0;
    we_cnt   = 0;
    re_cnt   = 0;
    err_cnt  = 0;
    bus.csb  = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < rises; i++) begin
      bus.sclk = 1'b0;
      bus.sdi  = (i < 24) ? frame[23 - i] : 1'b0;
      repeat (4) @(negedge clk);
      if (i >= 16 && i < 24) begin
        rd_bits[23 - i] = bus.sdo;
        if (bus.sdo_oe) oe_hits++;
      end else if (bus.sdo_oe) begin
        oe_stray++;
      end
      if (i == 5) busy_mid = busy;
      bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    bus.csb = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.sclk = 1'b0;
    bus.sdi  = b;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    logic [7:0]  rd_bits;
    logic        busy_mid;
    int          oe_hits;
    int          oe_stray;
    logic [23:0] rfrm;

    // Frames are {R/W, W1:W0, addr[12:0], data[7:0]}.
    vecs[0] = mk("write",      24'h0014A5, 24, 8'h00, 1, 0, 0, 13'h0014, 8'hA5, 1'b0, 8'h00, 0);
    vecs[1] = mk("read",       24'h800500, 24, 8'h3C, 0, 1, 0, 13'h0005, 8'hA5, 1'b1, 8'h3C, 8);
    vecs[2] = mk("abort10",    24'h0014A5, 10, 8'h00, 0, 0, 1, 13'h0005, 8'hA5, 1'b0, 8'h00, 0);
    vecs[3] = mk("write_max",  24'h1FFF5A, 24, 8'h00, 1, 0, 0, 13'h1FFF, 8'h5A, 1'b0, 8'h00, 0);
    vecs[4] = mk("badw_write", 24'h212377, 24, 8'h00, 0, 0, 1, 13'h1FFF, 8'h5A, 1'b0, 8'h00, 0);
    vecs[5] = mk("overrun26",  24'h0ABCC3, 26, 8'h00, 1, 0, 1, 13'h0ABC, 8'hC3, 1'b0, 8'h00, 0);
    vecs[6] = mk("badw_read",  24'hC00500, 24, 8'h3C, 0, 0, 1, 13'h0ABC, 8'hC3, 1'b0, 8'h00, 0);
    vecs[7] = mk("overrun25",  24'h000101, 25, 8'h00, 1, 0, 1, 13'h0001, 8'h01, 1'b0, 8'h00, 0);
    vecs[8] = mk("read_hi",    24'h900000, 24, 8'hA5, 0, 1, 0, 13'h1000, 8'h01, 1'b1, 8'hA5, 8);
    vecs[9] = mk("abort20",    24'h0014A5, 20, 8'h00, 0, 0, 1, 13'h0014, 8'h01, 1'b0, 8'h00, 0);

    rst           = 1'b1;
    bus.csb       = 1'b1;
    bus.sclk      = 1'b0;
    bus.sdi       = 1'b0;
    bus.reg_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.sdo",       32'(bus.sdo),       32'd0);
    check("rst.sdo_oe",    32'(bus.sdo_oe),    32'd0);
    check("rst.reg_we",    32'(bus.reg_we),    32'd0);
    check("rst.reg_re",    32'(bus.reg_re),    32'd0);
    check("rst.frame_err", 32'(frame_err),     32'd0);
    check("rst.busy",      32'(busy),          32'd0);
    check("rst.reg_addr",  32'(bus.reg_addr),  32'd0);
    check("rst.reg_wdata", 32'(bus.reg_wdata), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle.busy", 32'(busy), 32'd0);

    for (int v = 0; v < 10; v++) begin
      bus.reg_rdata = vecs[v].rdata;
      run_frame(vecs[v].frame, vecs[v].rises, rd_bits, oe_hits, oe_stray, busy_mid);
      check({vecs[v].name, ".we"},        32'(we_cnt),        32'(vecs[v].exp_we));
      check({vecs[v].name, ".re"},        32'(re_cnt),        32'(vecs[v].exp_re));
      check({vecs[v].name, ".frame_err"}, 32'(err_cnt),       32'(vecs[v].exp_err));
      check({vecs[v].name, ".reg_addr"},  32'(bus.reg_addr),  32'(vecs[v].exp_addr));
      check({vecs[v].name, ".reg_wdata"}, 32'(bus.reg_wdata), 32'(vecs[v].exp_wdata));
      check({vecs[v].name, ".oe_bits"},   32'(oe_hits),       32'(vecs[v].exp_oe));
      check({vecs[v].name, ".oe_stray"},  32'(oe_stray),      32'd0);
      check({vecs[v].name, ".busy_mid"},  32'(busy_mid),      32'd1);
      check({vecs[v].name, ".busy_end"},  32'(busy),          32'd0);
      check({vecs[v].name, ".sdo_end"},   32'(bus.sdo),       32'd0);
      if (vecs[v].chk_sdo) check({vecs[v].name, ".sdo_byte"}, 32'(rd_bits), 32'(vecs[v].exp_sdo));
    end

    // Reset pulsed after 12 bits while csb stays low. The remaining bits must
    // be ignored, and the frame that follows csb's return high must be accepted.
    rfrm    = 24'h002233;
    we_cnt  = 0;
    re_cnt  = 0;
    err_cnt = 0;
    bus.csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 12; i++) send_bit(rfrm[23 - i]);
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst.busy_in_rst", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 12; i < 24; i++) send_bit(rfrm[23 - i]);
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst.busy_held", 32'(busy), 32'd0);
    bus.csb = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst.we",        32'(we_cnt),        32'd0);
    check("midrst.re",        32'(re_cnt),        32'd0);
    check("midrst.frame_err", 32'(err_cnt),       32'd0);
    check("midrst.reg_addr",  32'(bus.reg_addr),  32'd0);
    check("midrst.reg_wdata", 32'(bus.reg_wdata), 32'd0);

    run_frame(rfrm, 24, rd_bits, oe_hits, oe_stray, busy_mid);
    check("postrst.we",        32'(we_cnt),        32'd1);
    check("postrst.frame_err", 32'(err_cnt),       32'd0);
    check("postrst.reg_addr",  32'(bus.reg_addr),  32'h0022);
    check("postrst.reg_wdata", 32'(bus.reg_wdata), 32'h33);
    check("postrst.busy_end",  32'(busy),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
